// File: rtl/output_line_scheduler_if.sv
// Readout-side bus of output_line_scheduler: line-RAM read port plus downstream
// valid/ready word stream. The scheduler uses the master modport.
interface output_line_scheduler_if #(
  parameter int ADDR_WIDTH = 12
);
  logic                  ram_rd_en;
  logic                  ram_rd_bank;
  logic [ADDR_WIDTH-1:0] ram_rd_addr;
  logic [31:0]           ram_rd_data;
  logic [31:0]           dout;
  logic                  dout_valid;
  logic                  dout_ready;

  modport master (
    output ram_rd_en, ram_rd_bank, ram_rd_addr,
    input  ram_rd_data,
    output dout, dout_valid,
    input  dout_ready
  );

  modport slave (
    input  ram_rd_en, ram_rd_bank, ram_rd_addr,
    output ram_rd_data,
    input  dout, dout_valid,
    output dout_ready
  );
endinterface

// File: rtl/output_line_scheduler.sv
// Ping-pong line RAM readout sequencer: one pending line slot, credit-limited reads
// into a 2-entry output FIFO. Optional per-line header word under `LINE_HEADER_EN.
module output_line_scheduler #(
  parameter int ADDR_WIDTH = 12,
  parameter int LCNT_WIDTH = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  frame_start_i,
  input  logic                  line_done_i,
  input  logic                  line_bank_i,
  input  logic [ADDR_WIDTH-1:0] line_words_i,
  output logic                  line_active_o,
  output logic [LCNT_WIDTH-1:0] line_count_o,
  output logic                  overflow_o,
  output_line_scheduler_if.master bus
);

  typedef enum logic [1:0] {
    S_IDLE,
`ifdef LINE_HEADER_EN
    S_HDR,
`endif
    S_READ,
    S_FLUSH
  } state_t;

  state_t                r_state;
  logic                  r_pend_valid;
  logic                  r_pend_bank;
  logic [ADDR_WIDTH-1:0] r_pend_words;
  logic                  r_bank;
  logic [ADDR_WIDTH-1:0] r_words;
  logic [ADDR_WIDTH-1:0] r_cnt;
  logic                  r_in_flight;
  logic [31:0]           r_buf [2];
  logic                  r_wr_ptr;
  logic                  r_rd_ptr;
  logic [1:0]            r_occ;
  logic                  r_hold_bank;
  logic [ADDR_WIDTH-1:0] r_hold_addr;
  logic [LCNT_WIDTH-1:0] r_line_count;
  logic                  r_overflow;
  logic                  r_line_active;

  logic                  w_pop_pend;
  logic                  w_out_pop;
  logic [2:0]            w_fill;
  logic                  w_rd_en;
  logic                  w_push_hdr;
  logic                  w_push;
  logic [31:0]           w_push_data;

  assign w_pop_pend = (r_state == S_IDLE) && r_pend_valid;
  assign w_out_pop  = (r_occ != 2'd0) && bus.dout_ready;

  // Slots committed after this cycle: a word leaving now frees its slot for a new strobe,
  // which is what sustains one word per cycle with only two buffer entries.
  assign w_fill  = {1'b0, r_occ} + {2'b00, r_in_flight} - {2'b00, w_out_pop};
  assign w_rd_en = (r_state == S_READ) && (r_cnt != r_words) && (w_fill < 3'd2);

`ifdef LINE_HEADER_EN
  logic [15:0] w_lcnt16;
  logic [31:0] w_header;

  if (LCNT_WIDTH >= 16) begin : g_lcnt_trunc
    assign w_lcnt16 = r_line_count[15:0];
  end else begin : g_lcnt_ext
    assign w_lcnt16 = {{(16 - LCNT_WIDTH){1'b0}}, r_line_count};
  end

  assign w_header    = {8'hA5, 7'd0, r_bank, w_lcnt16};
  assign w_push_hdr  = (r_state == S_HDR);
  assign w_push_data = w_push_hdr ? w_header : bus.ram_rd_data;
`else
  assign w_push_hdr  = 1'b0;
  assign w_push_data = bus.ram_rd_data;
`endif

  // The header is only pushed right after IDLE, when no RAM data can be returning.
  assign w_push = r_in_flight || w_push_hdr;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state       <= S_IDLE;
      r_pend_valid  <= 1'b0;
      r_pend_bank   <= 1'b0;
      r_pend_words  <= '0;
      r_bank        <= 1'b0;
      r_words       <= '0;
      r_cnt         <= '0;
      r_in_flight   <= 1'b0;
      r_wr_ptr      <= 1'b0;
      r_rd_ptr      <= 1'b0;
      r_occ         <= 2'd0;
      r_line_count  <= '0;
      r_overflow    <= 1'b0;
      r_line_active <= 1'b0;
    end else if (frame_start_i) begin
      r_state       <= S_IDLE;
      r_pend_valid  <= 1'b0;
      r_cnt         <= '0;
      r_in_flight   <= 1'b0;
      r_wr_ptr      <= 1'b0;
      r_rd_ptr      <= 1'b0;
      r_occ         <= 2'd0;
      r_line_count  <= '0;
      r_overflow    <= 1'b0;
      r_line_active <= 1'b0;
    end else begin
      r_in_flight <= w_rd_en;

      if (line_done_i) begin
        if (!r_pend_valid || w_pop_pend) begin
          r_pend_valid <= 1'b1;
          r_pend_bank  <= line_bank_i;
          r_pend_words <= line_words_i;
        end else begin
          r_overflow <= 1'b1;
        end
      end else if (w_pop_pend) begin
        r_pend_valid <= 1'b0;
      end

      if (w_push)    r_wr_ptr <= ~r_wr_ptr;
      if (w_out_pop) r_rd_ptr <= ~r_rd_ptr;
      r_occ <= r_occ + {1'b0, w_push} - {1'b0, w_out_pop};

      case (r_state)
        S_IDLE: begin
          if (r_pend_valid) begin
            r_bank        <= r_pend_bank;
            r_words       <= r_pend_words;
            r_cnt         <= '0;
            r_line_active <= 1'b1;
`ifdef LINE_HEADER_EN
            r_state       <= S_HDR;
`else
            r_state       <= S_READ;
`endif
          end
        end
`ifdef LINE_HEADER_EN
        S_HDR: r_state <= S_READ;
`endif
        S_READ: begin
          if (r_cnt == r_words) begin
            r_state <= S_FLUSH;
          end else if (w_rd_en) begin
            r_cnt <= r_cnt + ADDR_WIDTH'(1);
            if (r_cnt == r_words - ADDR_WIDTH'(1)) r_state <= S_FLUSH;
          end
        end
        S_FLUSH: begin
          if (!r_in_flight && (r_occ == 2'd0)) begin
            r_line_count  <= r_line_count + LCNT_WIDTH'(1);
            r_line_active <= 1'b0;
            r_state       <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // NOTE: FIFO storage has no reset; pointers and occupancy gate every read of it.
  always_ff @(posedge clk_i) begin
    if (w_push) r_buf[r_wr_ptr] <= w_push_data;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_hold_bank <= 1'b0;
      r_hold_addr <= '0;
    end else if (w_rd_en) begin
      r_hold_bank <= r_bank;
      r_hold_addr <= r_cnt;
    end
  end

  assign bus.ram_rd_en   = w_rd_en;
  assign bus.ram_rd_bank = w_rd_en ? r_bank : r_hold_bank;
  assign bus.ram_rd_addr = w_rd_en ? r_cnt : r_hold_addr;
  assign bus.dout_valid  = (r_occ != 2'd0);
  assign bus.dout        = (r_occ != 2'd0) ? r_buf[r_rd_ptr] : 32'd0;

  assign line_active_o = r_line_active;
  assign line_count_o  = r_line_count;
  assign overflow_o    = r_overflow;

endmodule
